// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge-magnitude filter.
// Raster-order pixels enter through a valid/ready port. Two line buffers
// and a sliding window form the 3x3 neighbourhood. One registered result
// is produced for each in-frame window position, one cycle after the pixel
// that completes the window is accepted.
// Optional feature: define SOBEL_THRESHOLD_EN to add thresh_i. The output
// then becomes a binary edge map: all ones or zero.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its data stable until that
// transfer. The input side is ready whenever the output register is empty
// or is being drained in the same cycle.
module sobel_stream #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 16,
    parameter int IMG_HEIGHT  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [PIXEL_WIDTH-1:0] in_pixel_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   mode_i,
`ifdef SOBEL_THRESHOLD_EN
    input  logic [PIXEL_WIDTH-1:0] thresh_i,
`endif
    output logic [PIXEL_WIDTH-1:0] out_pixel_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   out_last_o
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    // Four guard bits hold the worst-case gradient sum +/-4*(2^PW-1).
    localparam int GW = PIXEL_WIDTH + 4;

    // lb1 holds the line above the current one; lb2 holds the line above that.
    logic [PIXEL_WIDTH-1:0] lb1_q [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb2_q [IMG_WIDTH];

    // Window columns c-1 (suffix 1) and c-2 (suffix 2) for the top,
    // middle and bottom rows. Column c comes straight from the buffers and
    // the input.
    logic [PIXEL_WIDTH-1:0] top1_q, top2_q, mid1_q, mid2_q, bot1_q, bot2_q;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    logic                   out_valid_q, out_last_q;
    logic [PIXEL_WIDTH-1:0] out_pixel_q;

    logic                   accept, col_last, row_last, in_win;
    logic [PIXEL_WIDTH-1:0] top_c, mid_c, sat, result;
    logic signed [GW-1:0]   gx, gy;
    logic [GW-1:0]          ax, ay, mag;

    function automatic logic signed [GW-1:0] ext(input logic [PIXEL_WIDTH-1:0] v);
        return $signed({4'b0000, v});
    endfunction

    assign in_ready_o  = !out_valid_q || out_ready_i;
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = out_valid_q;
    assign out_pixel_o = out_pixel_q;
    assign out_last_o  = out_last_q;

    assign top_c    = lb2_q[col_q];
    assign mid_c    = lb1_q[col_q];
    assign col_last = (col_q == CW'(IMG_WIDTH - 1));
    assign row_last = (row_q == RW'(IMG_HEIGHT - 1));
    // Only windows lying entirely inside the frame produce output. This
    // mask also hides stale line-buffer data left over from the previous frame.
    assign in_win   = (row_q >= RW'(2)) && (col_q >= CW'(2));

    // Compute the gradients, the magnitude and the saturated result for the
    // window completed by the pixel now on the input.
    always_comb begin
        gx  = (ext(top_c) - ext(top2_q)) + ((ext(mid_c) - ext(mid2_q)) <<< 1)
            + (ext(in_pixel_i) - ext(bot2_q));
        gy  = (ext(bot2_q) - ext(top2_q)) + ((ext(bot1_q) - ext(top1_q)) <<< 1)
            + (ext(in_pixel_i) - ext(top_c));
        ax  = gx[GW-1] ? -gx : gx;
        ay  = gy[GW-1] ? -gy : gy;
        mag = mode_i ? ((ax > ay) ? ax : ay) : (ax + ay);
        sat = (|mag[GW-1:PIXEL_WIDTH]) ? '1 : mag[PIXEL_WIDTH-1:0];
`ifdef SOBEL_THRESHOLD_EN
        result = (sat >= thresh_i) ? '1 : '0;
`else
        result = sat;
`endif
    end

    // Compute the next raster position. Both counters wrap at the end of the frame.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Update the position counters and the output register. A new result
    // takes priority over draining the register, so back-to-back results
    // leave no bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (accept && in_win) begin
                out_valid_q <= 1'b1;
                out_pixel_q <= result;
                out_last_q  <= row_last && col_last;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Shift the window and the line buffers on every accepted pixel. These
    // registers have no reset because the in-frame mask hides their contents.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb2_q[col_q] <= mid_c;
            lb1_q[col_q] <= in_pixel_i;
            top2_q       <= top1_q;
            top1_q       <= top_c;
            mid2_q       <= mid1_q;
            mid1_q       <= mid_c;
            bot2_q       <= bot1_q;
            bot1_q       <= in_pixel_i;
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
// Testbench for sobel_stream (8-bit pixels, 8x8 frames).
// The reference model computes each output directly from a whole-frame
// pixel array using the Sobel kernel definition.
module tb_sobel_stream;
  localparam int PW = 8;
  localparam int W  = 8;
  localparam int H  = 8;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [PW-1:0] in_pixel_i = '0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic          mode_i = 1'b0;
  logic [PW-1:0] out_pixel_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic          out_last_o;
`ifdef SOBEL_THRESHOLD_EN
  logic [PW-1:0] thresh_i = 8'd5;
`endif

  always #5 clk = ~clk;

  sobel_stream #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .in_pixel_i (in_pixel_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .mode_i     (mode_i),
`ifdef SOBEL_THRESHOLD_EN
    .thresh_i   (thresh_i),
`endif
    .out_pixel_o(out_pixel_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_last_o (out_last_o)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [PW:0] exp_q[$];   // {last, pixel}
  int pix [H][W];
  int md  [H][W];
  int cur_exp_val = -1;    // constant expected magnitude for the frame, -1 = none
  int rdy_mode = 0;        // 0 always ready, 1 random, 2 one 5-cycle stall
  bit stall_done = 1'b0;
  int tot_outs = 0;
  int tot_sat = 0;

  typedef struct {
    int pat;      // 0 flat 100, 1 vertical step, 2 ramp r+c, 3 random
    int mode;     // 0, 1, or 2 = random per pixel
    int rdy;
    int gaps;
    int exp_n;
    int exp_val;
    int exp_sat;  // expected count of 255 outputs, -1 = unchecked
  } vec_t;
  vec_t vecs[9];

  // ---------------- reference model ----------------
  function automatic int post(input int m);
`ifdef SOBEL_THRESHOLD_EN
    return (m >= int'(thresh_i)) ? 255 : 0;
`else
    return m;
`endif
  endfunction

  function automatic int ref_mag(input int r, input int c);
    int gx, gy, ax, ay, m;
    gx = (pix[r-2][c] - pix[r-2][c-2]) + 2 * (pix[r-1][c] - pix[r-1][c-2])
       + (pix[r][c] - pix[r][c-2]);
    gy = (pix[r][c-2] - pix[r-2][c-2]) + 2 * (pix[r][c-1] - pix[r-2][c-1])
       + (pix[r][c] - pix[r-2][c]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    m  = (md[r][c] != 0) ? ((ax > ay) ? ax : ay) : (ax + ay);
    if (m > 255) m = 255;
    return post(m);
  endfunction

  task automatic build_frame(input int pat, input int mode);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (pat)
          0:       pix[r][c] = 100;
          1:       pix[r][c] = (c < 4) ? 0 : 255;
          2:       pix[r][c] = r + c;
          default: pix[r][c] = $urandom_range(0, 255);
        endcase
        md[r][c] = (mode == 2) ? $urandom_range(0, 1) : mode;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_pixel(input int p, input int m);
    bit acc;
    int t;
    in_pixel_i = PW'(p);
    mode_i     = m[0];
    in_valid_i = 1'b1;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = in_ready_o;
      @(posedge clk); #1;
      t++;
    end
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: in_ready_o stayed %0b, required 1", in_ready_o);
    end
    in_valid_i = 1'b0;
  endtask

  // Queue the model results for the first n_pix pixels, then drive them.
  task automatic send_frame(input int n_pix, input int gaps);
    for (int i = 0; i < n_pix; i++) begin
      if (i / W >= 2 && i % W >= 2)
        exp_q.push_back({(i == W * H - 1) ? 1'b1 : 1'b0, PW'(ref_mag(i / W, i % W))});
    end
    for (int i = 0; i < n_pix; i++) begin
      send_pixel(pix[i / W][i % W], md[i / W][i % W]);
      if (gaps != 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin @(posedge clk); #1; t++; end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d outputs still owed, required 0", exp_q.size());
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec++;
    if (out_valid_o !== 1'b0 || out_pixel_o !== '0 || out_last_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s: valid=%0b pixel=%0d last=%0b ready=%0b, required 0 0 0 1",
               tag, out_valid_o, out_pixel_o, out_last_o, in_ready_o);
    end
  endtask

  // ---------------- downstream ready control ----------------
  initial begin
    logic [PW-1:0] h_pix;
    logic          h_last;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1: out_ready_i = ($urandom_range(0, 3) != 0);
        2: begin
          if (!stall_done && out_valid_o) begin
            stall_done  = 1'b1;
            out_ready_i = 1'b0;
            h_pix  = out_pixel_o;
            h_last = out_last_o;
            for (int k = 0; k < 5; k++) begin
              @(negedge clk);
              n_vec++;
              if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || out_pixel_o !== h_pix || out_last_o !== h_last) begin
                n_err++;
                $display("FAIL stall_cycle%0d: ready=%0b valid=%0b pixel=%0d, required 0 1 %0d",
                         k, in_ready_o, out_valid_o, out_pixel_o, h_pix);
              end
              if (k < 4) begin @(posedge clk); #1; end
            end
          end else begin
            out_ready_i = 1'b1;
          end
        end
        default: out_ready_i = 1'b1;
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    bit            prev_hold;
    logic [PW-1:0] hold_p;
    logic          hold_l;
    logic [PW:0]   e;
    prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          n_vec++;
          if (out_valid_o !== 1'b1 || out_pixel_o !== hold_p || out_last_o !== hold_l) begin
            n_err++;
            $display("FAIL hold_stable: valid=%0b pixel=%0d last=%0b, required 1 %0d %0b",
                     out_valid_o, out_pixel_o, out_last_o, hold_p, hold_l);
          end
        end
        prev_hold = out_valid_o && !out_ready_i;
        hold_p = out_pixel_o;
        hold_l = out_last_o;
        if (out_valid_o && out_ready_i) begin
          tot_outs++;
          if (out_pixel_o == 8'hFF) tot_sat++;
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output: pixel=%0d last=%0b, required no output", out_pixel_o, out_last_o);
          end else begin
            e = exp_q.pop_front();
            if ({out_last_o, out_pixel_o} !== e) begin
              n_err++;
              $display("FAIL output: pixel=%0d last=%0b, required %0d %0b",
                       out_pixel_o, out_last_o, e[PW-1:0], e[PW]);
            end
          end
          if (cur_exp_val >= 0) begin
            n_vec++;
            if (int'(out_pixel_o) != post(cur_exp_val)) begin
              n_err++;
              $display("FAIL frame_const: pixel=%0d, required %0d", out_pixel_o, post(cur_exp_val));
            end
          end
        end
      end
    end
  end

  // ---------------- main test ----------------
  initial begin
    int s_outs, s_sat;
    // pat mode rdy gaps exp_n exp_val exp_sat
    vecs[0] = '{0, 0, 0, 0, 36,  0,  0};
    vecs[1] = '{1, 0, 0, 0, 36, -1, 12};
    vecs[2] = '{2, 0, 0, 0, 36, 16,  0};
    vecs[3] = '{2, 1, 0, 0, 36,  8,  0};
    vecs[4] = '{0, 0, 2, 0, 36,  0,  0};
    vecs[5] = '{3, 2, 1, 1, 36, -1, -1};
    vecs[6] = '{1, 1, 1, 1, 36, -1, 12};
    vecs[7] = '{3, 2, 1, 0, 36, -1, -1};
    vecs[8] = '{3, 0, 0, 1, 36, -1, -1};

    rst_i = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_reset_outputs("reset_state");
      @(posedge clk); #1;
    end
    rst_i = 1'b0;

    for (int v = 0; v < 9; v++) begin
      rdy_mode    = vecs[v].rdy;
      stall_done  = 1'b0;
      cur_exp_val = vecs[v].exp_val;
      s_outs = tot_outs;
      s_sat  = tot_sat;
      build_frame(vecs[v].pat, vecs[v].mode);
      send_frame(W * H, vecs[v].gaps);
      drain();
      n_vec++;
      if (tot_outs - s_outs != vecs[v].exp_n) begin
        n_err++;
        $display("FAIL frame%0d_count: %0d outputs, required %0d", v, tot_outs - s_outs, vecs[v].exp_n);
      end
`ifndef SOBEL_THRESHOLD_EN
      if (vecs[v].exp_sat >= 0) begin
        n_vec++;
        if (tot_sat - s_sat != vecs[v].exp_sat) begin
          n_err++;
          $display("FAIL frame%0d_sat: %0d saturated, required %0d", v, tot_sat - s_sat, vecs[v].exp_sat);
        end
      end
`endif
    end

    // Reset after 20 pixels of a frame: the pending result is discarded and
    // the next pixel starts a fresh frame at (0,0).
    rdy_mode    = 0;
    cur_exp_val = -1;
    build_frame(3, 2);
    send_frame(20, 0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_reset_outputs("mid_frame_reset");
      @(posedge clk); #1;
    end
    rst_i = 1'b0;
    exp_q.delete();
    s_outs = tot_outs;
    build_frame(3, 2);
    send_frame(W * H, 1);
    drain();
    n_vec++;
    if (tot_outs - s_outs != 36) begin
      n_err++;
      $display("FAIL post_reset_count: %0d outputs, required 36", tot_outs - s_outs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
